// File: rtl/tl_a_arbiter.sv
// TileLink A-channel arbiter: NREQ requesters share one downstream port, with D responses routed back by source index.
// Define TL_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.

package tl_pkg;
   localparam int unsigned TL_AW    = 32;
   localparam int unsigned TL_DW    = 64;
   localparam int unsigned TL_SZW   = 4;
   localparam int unsigned TL_SRCW  = 8;
   localparam int unsigned TL_SINKW = 2;

   localparam logic [2:0] A_PUT_FULL    = 3'd0;
   localparam logic [2:0] A_PUT_PARTIAL = 3'd1;
   localparam logic [2:0] A_GET         = 3'd4;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [2:0]          param;
      logic [TL_SZW-1:0]   size;
      logic [TL_SRCW-1:0]  source;
      logic [TL_AW-1:0]    address;
      logic [TL_DW/8-1:0]  mask;
      logic [TL_DW-1:0]    data;
      logic                corrupt;
   } A_chan_bits_t;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [1:0]          param;
      logic [TL_SZW-1:0]   size;
      logic [TL_SRCW-1:0]  source;
      logic [TL_SINKW-1:0] sink;
      logic                denied;
      logic [TL_DW-1:0]    data;
      logic                corrupt;
   } D_chan_bits_t;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [1:0]          param;
      logic [TL_SZW-1:0]   size;
      logic [TL_SRCW-1:0]  source;
      logic [TL_AW-1:0]    address;
   } B_chan_bits_t;

   typedef struct packed {
      logic [2:0]          opcode;
      logic [2:0]          param;
      logic [TL_SZW-1:0]   size;
      logic [TL_SRCW-1:0]  source;
      logic [TL_AW-1:0]    address;
      logic [TL_DW-1:0]    data;
      logic                corrupt;
   } C_chan_bits_t;

   typedef struct packed {
      logic [TL_SINKW-1:0] sink;
   } E_chan_bits_t;
endpackage

interface TL_BUS;
   logic                  a_valid;
   logic                  a_ready;
   tl_pkg::A_chan_bits_t  a_bits;
   logic                  b_valid;
   logic                  b_ready;
   tl_pkg::B_chan_bits_t  b_bits;
   logic                  c_valid;
   logic                  c_ready;
   tl_pkg::C_chan_bits_t  c_bits;
   logic                  d_valid;
   logic                  d_ready;
   tl_pkg::D_chan_bits_t  d_bits;
   logic                  e_valid;
   logic                  e_ready;
   tl_pkg::E_chan_bits_t  e_bits;

   // The arbiter side drives requests (A/C/E) and consumes responses (B/D).
   modport Slave (
      output a_valid, a_bits, b_ready, c_valid, c_bits, d_ready, e_valid, e_bits,
      input  a_ready, b_valid, b_bits, c_ready, d_valid, d_bits, e_ready
   );
   modport Master (
      input  a_valid, a_bits, b_ready, c_valid, c_bits, d_ready, e_valid, e_bits,
      output a_ready, b_valid, b_bits, c_ready, d_valid, d_bits, e_ready
   );
endinterface

module tl_a_arbiter #(
   parameter int unsigned NREQ       = 3,
   parameter int unsigned IDX_W      = 2,
   parameter int unsigned SRC_SHIFT  = 4,
   parameter int unsigned BEAT_BYTES = 8
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NREQ-1:0]      A_valid_i,
   output logic [NREQ-1:0]      A_ready_o,
   input  tl_pkg::A_chan_bits_t A_bits_i [NREQ],
   output logic [NREQ-1:0]      D_valid_o,
   input  logic [NREQ-1:0]      D_ready_i,
   output tl_pkg::D_chan_bits_t D_bits_o,
   output logic                 route_err_o,
   TL_BUS.Slave                 master
);

   localparam int unsigned    CNT_W  = 16;
   localparam logic [7:0]     LOG_BB = 8'($clog2(BEAT_BYTES));
   localparam logic [IDX_W:0] NREQ_W = (IDX_W+1)'(NREQ);

   typedef enum logic [0:0] {IDLE, BURST} state_e;

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   lock_q, lock_d;
   logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;
   logic               hold_vld_q, hold_vld_d;
   logic [IDX_W-1:0]   hold_idx_q, hold_idx_d;
   logic               route_err_q, route_err_d;

   logic [IDX_W-1:0]   search_start;
   logic [IDX_W-1:0]   search_idx;
   logic               search_found;
   logic [2*NREQ-1:0]  valid_dbl;
   logic [NREQ-1:0]    valid_rot;

   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_active;
   logic [NREQ-1:0]    gnt_valid_sh;
   logic               a_valid_m;
   logic               a_fire;
   logic [7:0]         a_size_ext;
   logic [CNT_W-1:0]   a_beats_m1;
   logic               a_is_put;

   logic [IDX_W-1:0]   d_idx;
   logic               d_hit;
   logic [NREQ-1:0]    d_ready_sh;
   logic               d_ready_m;

`ifdef TL_ARB_FIXED_PRIO_EN
   assign search_start = '0;
`else
   logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   assign search_start = rr_ptr_q;
`endif

   // Rotate the request vector so bit 0 is the requester at search_start.
   assign valid_dbl = {A_valid_i, A_valid_i} >> search_start;
   assign valid_rot = valid_dbl[NREQ-1:0];

   always_comb begin
      search_idx   = '0;
      search_found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (!search_found && valid_rot[k]) begin
            search_found = 1'b1;
            search_idx   = (int'(search_start) + k >= NREQ) ?
                           IDX_W'(int'(search_start) + k - NREQ) :
                           IDX_W'(int'(search_start) + k);
         end
      end
   end

   // A burst lock outranks the no-retract hold, which outranks a fresh search.
   always_comb begin
      gnt_idx    = search_idx;
      gnt_active = search_found;
      if (state_q == BURST) begin
         gnt_idx    = lock_q;
         gnt_active = 1'b1;
      end else if (hold_vld_q) begin
         gnt_idx    = hold_idx_q;
         gnt_active = 1'b1;
      end
   end

   assign gnt_valid_sh   = A_valid_i >> gnt_idx;
   assign a_valid_m      = rst_ni && gnt_active && gnt_valid_sh[0];
   assign a_fire         = a_valid_m && master.a_ready;
   assign master.a_valid = a_valid_m;
   assign master.a_bits  = A_bits_i[gnt_idx];

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_a_ready
         assign A_ready_o[gi] = rst_ni && gnt_active && (gnt_idx == IDX_W'(gi)) && master.a_ready;
      end
   endgenerate

   assign a_size_ext = 8'(master.a_bits.size);
   assign a_is_put   = (master.a_bits.opcode == tl_pkg::A_PUT_FULL) ||
                       (master.a_bits.opcode == tl_pkg::A_PUT_PARTIAL);

   always_comb begin
      if (a_size_ext <= LOG_BB) begin
         a_beats_m1 = '0;
      end else begin
         a_beats_m1 = (CNT_W'(1) << (a_size_ext - LOG_BB)) - CNT_W'(1);
      end
   end

   always_comb begin
      state_d    = state_q;
      lock_d     = lock_q;
      beat_cnt_d = beat_cnt_q;
      hold_vld_d = 1'b0;
      hold_idx_d = hold_idx_q;
`ifndef TL_ARB_FIXED_PRIO_EN
      rr_ptr_d   = rr_ptr_q;
`endif
      case (state_q)
         IDLE: begin
            hold_vld_d = a_valid_m && !master.a_ready;
            hold_idx_d = gnt_idx;
            if (a_fire) begin
`ifndef TL_ARB_FIXED_PRIO_EN
               rr_ptr_d = (int'(gnt_idx) + 1 >= NREQ) ? '0 : gnt_idx + 1'b1;
`endif
               if (a_is_put && (a_beats_m1 != '0)) begin
                  state_d    = BURST;
                  lock_d     = gnt_idx;
                  beat_cnt_d = a_beats_m1;
               end
            end
         end
         BURST: begin
            if (a_fire) begin
               beat_cnt_d = beat_cnt_q - 1'b1;
               if (beat_cnt_q <= CNT_W'(1)) begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // D channel: pure pass-through steered by the index inside source.
   assign d_idx      = master.d_bits.source[SRC_SHIFT +: IDX_W];
   assign d_hit      = {1'b0, d_idx} < NREQ_W;
   assign d_ready_sh = D_ready_i >> d_idx;
   assign d_ready_m  = d_hit ? d_ready_sh[0] : 1'b1;

   assign master.d_ready = rst_ni && d_ready_m;
   assign D_bits_o       = master.d_bits;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_d_valid
         assign D_valid_o[gi] = rst_ni && master.d_valid && d_hit && (d_idx == IDX_W'(gi));
      end
   endgenerate

   assign route_err_d = route_err_q || (master.d_valid && !d_hit);
   assign route_err_o = route_err_q;

   assign master.b_ready = 1'b0;
   assign master.c_valid = 1'b0;
   assign master.c_bits  = '0;
   assign master.e_valid = 1'b0;
   assign master.e_bits  = '0;

   logic unused_bce;
   assign unused_bce = ^{master.b_valid, master.b_bits, master.c_ready, master.e_ready};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         lock_q      <= '0;
         beat_cnt_q  <= '0;
         hold_vld_q  <= 1'b0;
         hold_idx_q  <= '0;
         route_err_q <= 1'b0;
`ifndef TL_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         lock_q      <= lock_d;
         beat_cnt_q  <= beat_cnt_d;
         hold_vld_q  <= hold_vld_d;
         hold_idx_q  <= hold_idx_d;
         route_err_q <= route_err_d;
`ifndef TL_ARB_FIXED_PRIO_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

endmodule

// File: tb/tb_tl_a_arbiter.sv
// Directed bench for tl_a_arbiter (default round-robin build): A arbitration, burst lock, grant hold, D routing, reset.

module tb_tl_a_arbiter;
   import tl_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [2:0]       req_valid;
   logic [2:0]       req_ready;
   A_chan_bits_t     req_bits [3];
   logic [2:0]       rsp_valid;
   logic [2:0]       rsp_ready;
   D_chan_bits_t     rsp_bits;
   logic             route_err;
   int               left [3];
   int               n_vec = 0;
   int               n_err = 0;

   always #5 clk = ~clk;

   TL_BUS bus ();

   tl_a_arbiter #(.NREQ(3), .IDX_W(2), .SRC_SHIFT(4), .BEAT_BYTES(8)) dut (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .A_valid_i   (req_valid),
      .A_ready_o   (req_ready),
      .A_bits_i    (req_bits),
      .D_valid_o   (rsp_valid),
      .D_ready_i   (rsp_ready),
      .D_bits_o    (rsp_bits),
      .route_err_o (route_err),
      .master      (bus)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("  ok %s = %0h", tag, got);
      end
   endtask

   task automatic req(input int r, input logic [2:0] op, input logic [3:0] size);
      req_bits[r]         = '0;
      req_bits[r].opcode  = op;
      req_bits[r].size    = size;
      req_bits[r].source  = 8'(16 * r + 1);
      req_bits[r].address = 32'(32'h1000 * (r + 1));
      left[r]             = (size <= 4'd3) ? 1 : (1 << (int'(size) - 3));
      req_valid[r]        = 1'b1;
   endtask

   // One cycle: check which requester fires and the ready vector, then retire fired beats.
   task automatic step(input string tag, input logic [2:0] exp_fire, input logic [2:0] exp_rdy);
      logic [2:0] fire;
      @(negedge clk);
      fire = req_valid & req_ready;
      check({tag, ".fire"}, 64'(fire), 64'(exp_fire));
      check({tag, ".rdy"}, 64'(req_ready), 64'(exp_rdy));
      @(posedge clk);
      #1;
      for (int r = 0; r < 3; r++) begin
         if (fire[r]) begin
            left[r]--;
            if (left[r] == 0) req_valid[r] = 1'b0;
         end
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      req_valid   = '0;
      rsp_ready   = '0;
      for (int r = 0; r < 3; r++) begin
         req_bits[r] = '0;
         left[r]     = 0;
      end
      bus.a_ready = 1'b1;
      bus.d_valid = 1'b0;
      bus.d_bits  = '0;
      bus.b_valid = 1'b0;
      bus.b_bits  = '0;
      bus.c_ready = 1'b0;
      bus.e_ready = 1'b0;

      // Reset holds every handshake output low even with a pending request
      req(0, A_GET, 4'd3);
      @(negedge clk);
      check("rst.rdy", 64'(req_ready), 64'h0);
      check("rst.aval", 64'(bus.a_valid), 64'h0);
      req_valid = '0;
      left[0]   = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("idle.rdy", 64'(req_ready), 64'h0);
      check("idle.dval", 64'(rsp_valid), 64'h0);
      check("idle.rerr", 64'(route_err), 64'h0);
      @(posedge clk);
      #1;

      // Three simultaneous Gets fire in order 0,1,2
      req(0, A_GET, 4'd3);
      req(1, A_GET, 4'd3);
      req(2, A_GET, 4'd3);
      step("rr.g0", 3'b001, 3'b001);
      step("rr.g1", 3'b010, 3'b010);
      step("rr.g2", 3'b100, 3'b100);

      // 4-beat Put from req1 is not interleaved, even across a valid gap
      req(0, A_GET, 4'd3);
      req(1, A_PUT_FULL, 4'd5);
      req(2, A_GET, 4'd3);
      step("bu.g0", 3'b001, 3'b001);
      step("bu.b1", 3'b010, 3'b010);
      step("bu.b2", 3'b010, 3'b010);
      req_valid[1] = 1'b0;
      step("bu.gap", 3'b000, 3'b010);
      req_valid[1] = 1'b1;
      step("bu.b3", 3'b010, 3'b010);
      step("bu.b4", 3'b010, 3'b010);
      step("bu.g2", 3'b100, 3'b100);

      // 2-beat PutPartial, then a size==log2(BEAT_BYTES) Put that is a single beat
      req(0, A_PUT_PARTIAL, 4'd4);
      req(2, A_GET, 4'd3);
      step("pp.b1", 3'b001, 3'b001);
      step("pp.b2", 3'b001, 3'b001);
      step("pp.g2", 3'b100, 3'b100);
      req(0, A_PUT_FULL, 4'd3);
      req(1, A_GET, 4'd3);
      step("p1.g0", 3'b001, 3'b001);
      step("p1.g1", 3'b010, 3'b010);

      // Grant hold: req0 stalled, req2 arrives (and would win the search), grant must stay on req0
      bus.a_ready = 1'b0;
      req(0, A_GET, 4'd3);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check("hold.src", 64'(bus.a_bits.source[5:4]), 64'h0);
         check("hold.rdy", 64'(req_ready), 64'h0);
         @(posedge clk);
         #1;
      end
      req(2, A_GET, 4'd3);
      @(negedge clk);
      check("hold.src2", 64'(bus.a_bits.source[5:4]), 64'h0);
      check("hold.aval", 64'(bus.a_valid), 64'h1);
      @(posedge clk);
      #1 bus.a_ready = 1'b1;
      step("hold.rel", 3'b001, 3'b001);
      step("hold.g2", 3'b100, 3'b100);

      // D routing to index 2, including back-pressure
      bus.d_valid        = 1'b1;
      bus.d_bits         = '0;
      bus.d_bits.source  = 8'h25;
      bus.d_bits.data    = 64'hDEAD_BEEF_0123_4567;
      rsp_ready          = 3'b100;
      @(negedge clk);
      check("d2.val", 64'(rsp_valid), 64'h4);
      check("d2.rdy", 64'(bus.d_ready), 64'h1);
      check("d2.data", rsp_bits.data, 64'hDEAD_BEEF_0123_4567);
      rsp_ready = 3'b011;
      #1;
      check("d2.bp", 64'(bus.d_ready), 64'h0);
      check("d2.valbp", 64'(rsp_valid), 64'h4);
      @(posedge clk);
      #1;
      bus.d_bits.source = 8'h05;
      rsp_ready         = 3'b001;
      @(negedge clk);
      check("d0.val", 64'(rsp_valid), 64'h1);
      check("d0.rdy", 64'(bus.d_ready), 64'h1);
      check("d0.rerr", 64'(route_err), 64'h0);
      @(posedge clk);
      #1;

      // Out-of-range index is sunk and flags a sticky error
      bus.d_bits.source = 8'h35;
      rsp_ready         = 3'b111;
      @(negedge clk);
      check("dx.val", 64'(rsp_valid), 64'h0);
      check("dx.rdy", 64'(bus.d_ready), 64'h1);
      check("dx.rerr0", 64'(route_err), 64'h0);
      @(posedge clk);
      #1 bus.d_valid = 1'b0;
      @(negedge clk);
      check("dx.rerr1", 64'(route_err), 64'h1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("dx.sticky", 64'(route_err), 64'h1);
      @(posedge clk);
      #1;

      // Reset during beat 2 of a 4-beat Put
      bus.d_valid       = 1'b1;
      bus.d_bits.source = 8'h05;
      rsp_ready         = 3'b001;
      req(1, A_PUT_FULL, 4'd5);
      step("rb.b1", 3'b010, 3'b010);
      @(negedge clk);
      check("rb.b2", 64'(req_valid & req_ready), 64'h2);
      #1 rst_n = 1'b0;
      #1;
      check("rb.rdy", 64'(req_ready), 64'h0);
      check("rb.dval", 64'(rsp_valid), 64'h0);
      check("rb.rerr", 64'(route_err), 64'h0);
      check("rb.aval", 64'(bus.a_valid), 64'h0);
      check("rb.drdy", 64'(bus.d_ready), 64'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n       = 1'b1;
      req_valid   = '0;
      left[1]     = 0;
      bus.d_valid = 1'b0;
      req(1, A_GET, 4'd3);
      step("rb.g1", 3'b010, 3'b010);
      req(0, A_GET, 4'd3);
      step("rb.g0", 3'b001, 3'b001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tl_a_arbiter.md
Name: tl_a_arbiter

Overview:
- Shares one TileLink master port (TL_BUS.Slave view) between NREQ on-chip requesters, e.g. I-cache refill, D-cache and PTW.
- Arbitrates the A channel round-robin and holds the grant for the full length of a multi-beat Put.
- Routes D-channel responses back to the originating requester using the index field of d_bits.source.
- B, C and E channels are not arbitrated; they connect to requester 0 (the coherent D-cache) outside this block.

Parameters:
- NREQ, 3, number of requesters (2..8)
- IDX_W, 2, width of the requester index field; must satisfy 2^IDX_W >= NREQ
- SRC_SHIFT, 4, bit position of the requester index inside the source field; index = source[SRC_SHIFT +: IDX_W]
- BEAT_BYTES, 8, data bytes per A/D beat

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- A_valid_i  in  NREQ  per-requester A valid
- A_ready_o  out  NREQ  per-requester A ready
- A_bits_i  in  NREQ x tl_pkg::A_chan_bits_t  per-requester A payload; the requester has already placed its index in source
- D_valid_o  out  NREQ  per-requester D valid
- D_ready_i  in  NREQ  per-requester D ready
- D_bits_o  out  tl_pkg::D_chan_bits_t  D payload, broadcast to all requesters
- route_err_o  out  1  sticky flag: a D beat arrived with index >= NREQ
- master  TL_BUS.Slave  shared downstream port; only the a_* and d_* signals are used, b_ready/c_*/e_* are tied inactive

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, beat_cnt=0, route_err_o=0. All A_ready_o=0 and all D_valid_o=0 (both are combinational on registered state and inputs).
- State machine:
  - IDLE: grant = first requester with A_valid_i set, searching from rr_ptr upward with wrap. master.a_valid = A_valid_i[grant]; master.a_bits = A_bits_i[grant]; A_ready_o[grant] = master.a_ready; all other ready bits = 0.
  - On a fire in IDLE (valid & ready), with B = 2^size / BEAT_BYTES:
    - Op is PutFullData/PutPartialData and B > 1: lock=grant, beat_cnt=B-1, state=BURST.
    - Otherwise: stay in IDLE.
    - In both cases rr_ptr = grant+1, wrapping to 0 at NREQ.
  - BURST: only requester lock is connected, and it is connected even when its valid drops. Each fire decrements beat_cnt. A fire with beat_cnt==1 returns to IDLE. No other requester is granted.
- Arbitration is combinational, so a grant costs zero latency: a request in cycle N with master.a_ready=1 fires in cycle N.
- A_bits are not required to be stable across a deasserted valid; once presented, the arbiter does not change its grant while master.a_valid=1 && !master.a_ready (grant hold register). This preserves the TileLink no-retract rule.
- Size arithmetic: beat count is computed from the size field zero-extended to 8 bits. size <= log2(BEAT_BYTES) counts as a single beat.
- D routing:
  - idx = master.d_bits.source[SRC_SHIFT +: IDX_W]; D_valid_o[idx] = master.d_valid; master.d_ready = D_ready_i[idx]. Pass-through with no buffering and no added latency.
  - idx >= NREQ: master.d_ready = 1 (the beat is sunk), no D_valid_o asserted, route_err_o set to 1 and held until reset.
- Simultaneous A and D activity is independent; there are no cross-channel interlocks.
- Reset mid-burst abandons the burst; recovering the downstream state is the system's responsibility.

Optional Feature:
- TL_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins; rr_ptr is removed and the search always starts at 0.
- Not defined: round-robin as described above.
- Burst lock and D routing are identical in both modes.

Test Plan:
- All three requesters raise Get (size=3) at once, master.a_ready=1 -> fires in order 0,1,2 on consecutive cycles; rr_ptr=0 afterwards.
- Req1 PutFullData size=5 (4 beats) while req0 and req2 keep requesting -> 4 consecutive req1 beats with no interleave; next grant goes to req2.
- Req0 valid, master.a_ready=0 for 3 cycles, then req2 also raises valid -> grant stays on req0 until it fires.
- D beat with source=0x25 (idx 2) and D_ready_i=3'b100 -> D_valid_o=3'b100, master.d_ready=1; with D_ready_i=3'b011 -> master.d_ready=0.
- D beat with source=0x35 (idx 3, NREQ=3) -> beat sunk, D_valid_o=0, route_err_o rises the next cycle and stays high.
- rst_ni asserted during beat 2 of a 4-beat Put -> all outputs 0 immediately; after release, a new Get from req1 is granted.
